bounding_box: RTL and testbench
===============================

BOUNDING_BOX -- requirements
Module: bounding_box

Interface
REQ-001 The block SHALL have parameter COORD_W, default 11, giving the width of the pixel and line coordinates.
REQ-002 The block SHALL have parameter BOX_COLOR, default 24'hff0000, giving the overlay pixel colour.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk  input  1  pixel clock; all logic is on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port de_in  input  1  data enable, from the median_5_5 output.
REQ-007 Port h_sync_in  input  1  horizontal sync.
REQ-008 Port v_sync_in  input  1  vertical sync, active-high.
REQ-009 Port pixel_in  input  24  binary video; bit 0 is the foreground mask.
REQ-010 Port de_out, h_sync_out, v_sync_out  output  1 each  syncs delayed by one cycle.
REQ-011 Port pixel_out  output  24  video delayed by one cycle, with the optional overlay applied.
REQ-012 Port x_min, x_max, y_min, y_max  output  COORD_W each  bounding box latched for the last complete frame.
REQ-013 Port box_valid  output  1  set when the latched frame contained at least one foreground pixel.
REQ-014 Port frame_done  output  1  one-cycle pulse when the latched outputs update.

Function
REQ-015 The x counter SHALL increment on each cycle with de_in=1, starting at 0 for the first active pixel of a line.
REQ-016 The x counter SHALL clear on each cycle with de_in=0.
REQ-017 The y counter SHALL increment on each falling edge of de_in.
REQ-018 The y counter SHALL clear on the rising edge of v_sync_in.
REQ-019 Both counters SHALL saturate at 2^COORD_W-1 and SHALL NOT wrap.
REQ-020 On a foreground pixel (de_in=1 and pixel_in[0]=1), the working min/max registers SHALL update to include the current (x,y).
REQ-021 The first foreground pixel of a frame SHALL load all four working registers with its (x,y).
REQ-022 The state machine SHALL have two states: ARMING and RUN.
REQ-023 The state SHALL be ARMING after reset and SHALL move to RUN on the first v_sync_in rising edge; that edge SHALL NOT produce a frame_done pulse.
REQ-024 In RUN, each v_sync_in rising edge SHALL, on the same clock edge:
  - copy the working box into the x_min/x_max/y_min/y_max outputs;
  - set box_valid to the working "seen" flag;
  - pulse frame_done for one cycle;
  - clear the working registers and the seen flag.
REQ-025 At frame end with no foreground pixel seen, the outputs SHALL be x_min=x_max=y_min=y_max=0 and box_valid=0.
REQ-026 The syncs and pixel SHALL have a fixed latency of exactly 1 cycle, independent of frame content.
REQ-027 The latched outputs SHALL hold their values between frame_done pulses.

Reset
REQ-028 While rst=1, the block SHALL clear all outputs, counters, and working registers to 0 and set the state to ARMING.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame, so that the next frame_done reports only the first full frame after reset.

Configuration
REQ-030 With macro BBOX_OVERLAY_EN defined, pixel_out SHALL be BOX_COLOR on pixels that meet all of the following:
  - de_in=1 and box_valid=1;
  - x equals x_min or x_max with y between y_min and y_max inclusive, or y equals y_min or y_max with x between x_min and x_max inclusive.
REQ-031 The overlay SHALL use the latched box from the previous frame.
REQ-032 On all other pixels with BBOX_OVERLAY_EN defined, and on every pixel without it, pixel_out SHALL equal the pixel_in value from one cycle earlier.
REQ-033 Without BBOX_OVERLAY_EN, no overlay comparators SHALL be synthesised.

Structure
REQ-034 The vb_defs.vh include file SHALL define the default COORD_W, the default BOX_COLOR, and the state encodings (ARMING=1'b0, RUN=1'b1).
REQ-035 The position tracking SHALL be a single sub-module, pixel_position_counter, containing the x/y counters with saturation and edge detection for de and v_sync.
REQ-036 The 1-cycle sync alignment SHALL reuse the existing delay module with WIDTH=3 and DELAY=1.

Verification
REQ-037 Reset, one discarded frame, then a 1280x720 frame with a single foreground pixel at (100,50) SHALL give, on the next v_sync rise, x_min=x_max=100, y_min=y_max=50, box_valid=1, and one frame_done pulse.
REQ-038 A frame with foreground pixels at (10,5), (600,5), and (300,400) SHALL latch the box (10,600,5,400).
REQ-039 An all-background frame after a valid frame SHALL give box_valid=0, all coordinates 0, and still one frame_done pulse.
REQ-040 Asserting rst at line 300 SHALL return all outputs to 0; the following v_sync rise SHALL give no frame_done; the next full frame SHALL report correctly.
REQ-041 With BBOX_OVERLAY_EN and a latched box (10,600,5,400), the next frame SHALL have pixel_out=ff0000 at (10,200) and at (300,5), and SHALL equal the input delayed by one cycle at (11,200) and at (700,5).
REQ-042 With COORD_W=8 and a foreground pixel at x=300, x_max SHALL be 255 (saturated).

Source files
------------

// File: rtl/bounding_box_pkg.sv
// bounding_box_pkg: shared defaults and FSM state encodings for the bounding box block
//   COORD_W_DEF   default coordinate width
//   BOX_COLOR_DEF default overlay colour
//   ARMING/RUN    FSM state encodings
package bounding_box_pkg;
  localparam int COORD_W_DEF = 11;
  localparam logic [23:0] BOX_COLOR_DEF = 24'hff0000;
  localparam logic [0:0] ARMING = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
endpackage

// File: rtl/bounding_box_if.sv
// bounding_box_if: video stream bundle (data enable, syncs, 24-bit pixel)
//   master drives de/h_sync/v_sync/pixel, slave receives them
interface bounding_box_if;
  logic de;
  logic h_sync;
  logic v_sync;
  logic [23:0] pixel;
  modport master(output de, h_sync, v_sync, pixel);
  modport slave(input de, h_sync, v_sync, pixel);
endinterface

// File: rtl/bounding_box_delay.sv
// delay: WIDTH-bit shift register of DELAY stages with async reset
//   clk, rst  clock and async active-high reset
//   d, q      input and delayed output
module delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DELAY];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= d;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DELAY-1];
endmodule

// File: rtl/bounding_box_pixel_position_counter.sv
// pixel_position_counter: saturating x/y position of the current pixel plus v_sync rise detect
//   clk, rst  clock and async active-high reset
//   de        data enable; x counts active pixels, y counts de falling edges
//   v_sync    vertical sync; its rising edge clears y and is reported on v_rise
//   x, y      position of the pixel presented this cycle
module pixel_position_counter #(
  parameter int COORD_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               de,
  input  logic               v_sync,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               v_rise
);
  localparam logic [COORD_W-1:0] MAX = '1;
  logic de_q, vs_q;
  assign v_rise = v_sync & ~vs_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x <= '0;
      y <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= de;
      vs_q <= v_sync;
      x <= !de ? '0 : (x == MAX ? x : x + 1'b1);
      y <= v_rise ? '0 : (de_q && !de && y != MAX) ? y + 1'b1 : y;
    end
endmodule

// File: rtl/bounding_box.sv
// bounding_box: per-frame bounding box of foreground pixels with optional outline overlay
//   clk, rst                   pixel clock, async active-high reset
//   vid_in                     input video (pixel bit 0 = foreground mask)
//   vid_out                    video delayed one cycle, overlay applied when enabled
//   x_min/x_max/y_min/y_max    box latched at the end of the last complete frame
//   box_valid                  latched frame contained foreground
//   frame_done                 one-cycle pulse when the latched box updates
//   BBOX_OVERLAY_EN            define to draw the previous frame's box in BOX_COLOR
module bounding_box
  import bounding_box_pkg::*;
#(
  parameter int          COORD_W   = COORD_W_DEF,
  parameter logic [23:0] BOX_COLOR = BOX_COLOR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  bounding_box_if.slave      vid_in,
  bounding_box_if.master     vid_out,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max,
  output logic               box_valid,
  output logic               frame_done
);
  logic [COORD_W-1:0] x, y, wx_min, wx_max, wy_min, wy_max;
  logic [2:0] sync_q;
  logic [0:0] state;
  logic v_rise, seen, fg, hit;
  pixel_position_counter #(.COORD_W(COORD_W)) u_pos (
    .clk(clk), .rst(rst), .de(vid_in.de), .v_sync(vid_in.v_sync),
    .x(x), .y(y), .v_rise(v_rise)
  );
  delay #(.WIDTH(3), .DELAY(1)) u_sync (
    .clk(clk), .rst(rst),
    .d({vid_in.de, vid_in.h_sync, vid_in.v_sync}), .q(sync_q)
  );
  assign {vid_out.de, vid_out.h_sync, vid_out.v_sync} = sync_q;
  assign fg = vid_in.de & vid_in.pixel[0];
  // working box; the first foreground pixel of a frame loads all four bounds
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      seen <= 1'b0;
      wx_min <= '0;
      wx_max <= '0;
      wy_min <= '0;
      wy_max <= '0;
    end else if (v_rise) begin
      seen <= 1'b0;
      wx_min <= '0;
      wx_max <= '0;
      wy_min <= '0;
      wy_max <= '0;
    end else if (fg) begin
      seen <= 1'b1;
      wx_min <= (!seen || x < wx_min) ? x : wx_min;
      wx_max <= (!seen || x > wx_max) ? x : wx_max;
      wy_min <= (!seen || y < wy_min) ? y : wy_min;
      wy_max <= (!seen || y > wy_max) ? y : wy_max;
    end
  // the first v_sync rise after reset only arms; later rises publish the frame
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARMING;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      box_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= v_rise && state == RUN;
      if (v_rise) state <= RUN;
      if (v_rise && state == RUN) begin
        x_min <= wx_min;
        x_max <= wx_max;
        y_min <= wy_min;
        y_max <= wy_max;
        box_valid <= seen;
      end
    end
`ifdef BBOX_OVERLAY_EN
  logic on_col, on_row;
  assign on_col = (x == x_min || x == x_max) && y >= y_min && y <= y_max;
  assign on_row = (y == y_min || y == y_max) && x >= x_min && x <= x_max;
  assign hit = vid_in.de && box_valid && (on_col || on_row);
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) vid_out.pixel <= '0;
    else vid_out.pixel <= hit ? BOX_COLOR : vid_in.pixel;
endmodule

// File: tb/tb_bounding_box.sv
// tb_bounding_box: directed frames checked against a frame-level model of the bounding box
module tb_bounding_box;
  localparam int W = 11;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  bounding_box_if vin();
  bounding_box_if vout();
  bounding_box_if vout8();
  logic [W-1:0] x_min, x_max, y_min, y_max;
  logic box_valid, frame_done;
  logic [7:0] x_min8, x_max8, y_min8, y_max8;
  logic box_valid8, frame_done8;
  bounding_box #(.COORD_W(W)) dut (
    .clk(clk), .rst(rst), .vid_in(vin), .vid_out(vout),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .box_valid(box_valid), .frame_done(frame_done)
  );
  bounding_box #(.COORD_W(8)) dut8 (
    .clk(clk), .rst(rst), .vid_in(vin), .vid_out(vout8),
    .x_min(x_min8), .x_max(x_max8), .y_min(y_min8), .y_max(y_max8),
    .box_valid(box_valid8), .frame_done(frame_done8)
  );
  int total = 0, bad = 0, fd_cnt = 0, fd8_cnt = 0;
  int cur_x = -1, cur_y = -1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction
  // model: the frame's foreground points, and the box published at each armed v_sync rise
  int px[$], py[$];
  int m_xmin, m_xmax, m_ymin, m_ymax;
  bit m_valid, armed, vs_q, l_de;
  int l_x, l_y;
  logic [23:0] l_pix, e_pix;
  logic [2:0] e_sync;
  logic e_fd;
`ifdef BBOX_OVERLAY_EN
  function automatic bit on_box(input int x, input int y);
    return ((x == m_xmin || x == m_xmax) && y >= m_ymin && y <= m_ymax) ||
           ((y == m_ymin || y == m_ymax) && x >= m_xmin && x <= m_xmax);
  endfunction
`endif
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_sync = '0; e_pix = '0; e_fd = 1'b0;
      m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0; m_valid = 0;
      armed = 0; vs_q = 0; l_de = 0;
      px.delete(); py.delete();
    end else begin
      l_de = vin.de; l_x = cur_x; l_y = cur_y; l_pix = vin.pixel;
      e_sync = {vin.de, vin.h_sync, vin.v_sync};
      e_pix = vin.pixel;
`ifdef BBOX_OVERLAY_EN
      if (vin.de && m_valid && on_box(sat(cur_x), sat(cur_y))) e_pix = 24'hff0000;
`endif
      e_fd = 1'b0;
      if (vin.v_sync && !vs_q) begin
        if (armed) begin
          m_valid = px.size() > 0;
          m_xmin = m_valid ? MAXC : 0; m_xmax = 0; m_ymin = m_valid ? MAXC : 0; m_ymax = 0;
          foreach (px[i]) begin
            if (sat(px[i]) < m_xmin) m_xmin = sat(px[i]);
            if (sat(px[i]) > m_xmax) m_xmax = sat(px[i]);
            if (sat(py[i]) < m_ymin) m_ymin = sat(py[i]);
            if (sat(py[i]) > m_ymax) m_ymax = sat(py[i]);
          end
          e_fd = 1'b1;
        end
        armed = 1;
        px.delete(); py.delete();
      end else if (vin.de && vin.pixel[0]) begin
        px.push_back(cur_x); py.push_back(cur_y);
      end
      vs_q = vin.v_sync;
    end
  end
  int probe_x[4] = '{10, 11, 300, 700};
  int probe_y[4] = '{200, 200, 5, 5};
  logic [23:0] cap_out[4], cap_in[4];
  always @(negedge clk) begin
    chk("sync", {vout.de, vout.h_sync, vout.v_sync}, e_sync);
    chk("pixel", vout.pixel, e_pix);
    chk("frame_done", frame_done, e_fd);
    chk("box", {box_valid, x_min, x_max, y_min, y_max},
        {m_valid, W'(m_xmin), W'(m_xmax), W'(m_ymin), W'(m_ymax)});
    if (frame_done) fd_cnt++;
    if (frame_done8) fd8_cnt++;
    if (l_de)
      for (int p = 0; p < 4; p++)
        if (l_x == probe_x[p] && l_y == probe_y[p]) begin
          cap_out[p] = vout.pixel;
          cap_in[p] = l_pix;
        end
  end
  task automatic box_is(input string n, input int a, input int b, input int c, input int d, input bit v);
    chk(n, {box_valid, x_min, x_max, y_min, y_max}, {v, W'(a), W'(b), W'(c), W'(d)});
  endtask
  task automatic cyc(input bit de, input bit hs, input bit vs, input logic [23:0] pix, input int x, input int y);
    vin.de = de; vin.h_sync = hs; vin.v_sync = vs; vin.pixel = pix;
    cur_x = de ? x : -1; cur_y = de ? y : -1;
    @(posedge clk); #1;
  endtask
  task automatic vs_pulse();
    repeat (3) cyc(0, 0, 1, '0, 0, 0);
    repeat (2) cyc(0, 0, 0, '0, 0, 0);
  endtask
  int fgx[$], fgy[$], long_y[$], long_len[$];
  int rst_line = -1;
  task automatic lines(input int n);
    for (int y = 0; y < n; y++) begin
      int len;
      logic [23:0] p;
      len = 2;
      if (y == rst_line) begin
        rst = 1'b1;
        repeat (2) cyc(0, 0, 0, '0, 0, 0);
        box_is("rst_box", 0, 0, 0, 0, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_pixel", vout.pixel, 0);
        rst = 1'b0;
      end
      foreach (fgy[i]) if (fgy[i] == y && fgx[i] + 2 > len) len = fgx[i] + 2;
      foreach (long_y[i]) if (long_y[i] == y && long_len[i] > len) len = long_len[i];
      for (int x = 0; x < len; x++) begin
        p = 24'($urandom());
        p[0] = 1'b0;
        foreach (fgx[i]) if (fgx[i] == x && fgy[i] == y) p[0] = 1'b1;
        cyc(1, 0, 0, p, x, y);
      end
      cyc(0, 1, 0, '0, 0, 0);
      cyc(0, 0, 0, '0, 0, 0);
    end
  endtask
  initial begin
    rst = 1'b1;
    vin.de = 0; vin.h_sync = 0; vin.v_sync = 0; vin.pixel = '0;
    repeat (3) @(posedge clk);
    #1;
    box_is("reset_box", 0, 0, 0, 0, 0);
    chk("reset_fd", frame_done, 0);
    chk("reset_out", {vout.de, vout.h_sync, vout.v_sync, vout.pixel}, 0);
    rst = 1'b0;
    fgx = '{3}; fgy = '{3};
    lines(5);
    vs_pulse();
    chk("arm_no_fd", fd_cnt, 0);
    fgx = '{100}; fgy = '{50}; long_y = '{50}; long_len = '{1280};
    lines(720);
    vs_pulse();
    box_is("single_px", 100, 100, 50, 50, 1);
    chk("fd_count1", fd_cnt, 1);
    fgx = '{10, 600, 300}; fgy = '{5, 5, 400}; long_y.delete(); long_len.delete();
    lines(401);
    vs_pulse();
    box_is("three_px", 10, 600, 5, 400, 1);
    chk("fd_count2", fd_cnt, 2);
    long_y = '{5, 200}; long_len = '{701, 701};
    for (int p = 0; p < 4; p++) begin cap_out[p] = 24'h123456; cap_in[p] = '0; end
    lines(401);
`ifdef BBOX_OVERLAY_EN
    chk("ov_10_200", cap_out[0], 24'hff0000);
    chk("ov_300_5", cap_out[2], 24'hff0000);
`else
    chk("ov_10_200", cap_out[0], cap_in[0]);
    chk("ov_300_5", cap_out[2], cap_in[2]);
`endif
    chk("ov_11_200", cap_out[1], cap_in[1]);
    chk("ov_700_5", cap_out[3], cap_in[3]);
    vs_pulse();
    box_is("repeat_box", 10, 600, 5, 400, 1);
    fgx.delete(); fgy.delete(); long_y.delete(); long_len.delete();
    lines(10);
    vs_pulse();
    box_is("empty_frame", 0, 0, 0, 0, 0);
    chk("fd_count4", fd_cnt, 4);
    fgx = '{50}; fgy = '{20}; rst_line = 300;
    lines(500);
    rst_line = -1;
    vs_pulse();
    chk("post_rst_no_fd", fd_cnt, 4);
    box_is("post_rst_box", 0, 0, 0, 0, 0);
    fgx = '{7}; fgy = '{2};
    lines(10);
    vs_pulse();
    box_is("after_rst_frame", 7, 7, 2, 2, 1);
    fgx = '{300}; fgy = '{3};
    lines(5);
    vs_pulse();
    box_is("w11_x300", 300, 300, 3, 3, 1);
    chk("w8_sat", {box_valid8, x_min8, x_max8, y_min8, y_max8}, {1'b1, 8'd255, 8'd255, 8'd3, 8'd3});
    chk("fd_total", fd_cnt, 6);
    chk("fd8_total", fd8_cnt, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
